wb_reg_bank: RTL

Parametrised Wishbone-classic (pipelined-ack) register bank generalising the single-register slave to NREGS registers of DATA_W bits. Each register has a preset reset value, byte-lane write masking, a one-cycle write-strobe output, and an optional read-only mode that returns a fabric input. Accesses to unmapped word addresses terminate with an error instead of an ack. It sits between the Wishbone interconnect and fabric control/status logic.

---
 rtl/wb_reg_bank_if.sv | 29 ++
 rtl/wb_reg_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_reg_bank_if.sv
// Wishbone classic (pipelined-ack) bus bundle for wb_reg_bank.
// Signal names keep the slave-side _i/_o suffixes so the bus reads like the port list.
// Handshake: a request is one cycle with cyc & stb high; the slave answers with exactly one
// of ack/err one cycle later, and stall is high only while a request waits for its termination.
interface wb_reg_bank_if #(
    parameter int ADR_W = 4
);
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [ADR_W-1:0] wb_adr_i;
    logic [3:0]       wb_sel_i;
    logic [31:0]      wb_dat_i;
    logic             wb_ack_o;
    logic             wb_err_o;
    logic             wb_rty_o;
    logic             wb_stall_o;
    logic [31:0]      wb_dat_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );
endinterface

// File: rtl/wb_reg_bank.sv
// Wishbone register bank: NREGS registers of DATA_W bits with preset values,
// byte-lane write masking, one-cycle write strobes and optional read-only slots
// that return a fabric input. Unmapped word addresses terminate with err.
module wb_reg_bank #(
    parameter int                      NREGS   = 4,
    parameter int                      DATA_W  = 32,
    parameter int                      ADR_W   = 4,
    parameter logic [NREGS*DATA_W-1:0] PRESET  = '0,
    parameter logic [NREGS-1:0]        RO_MASK = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    wb_reg_bank_if.slave              wb,
    output logic [NREGS*DATA_W-1:0]   regs_o,
    output logic [NREGS-1:0]          wstrb_o,
    input  logic [NREGS*DATA_W-1:0]   ro_i
);
    localparam int IDX_W = ADR_W - 2;

    logic              en;
    logic              rd_req;
    logic              wr_req;
    logic              rip;
    logic              wip;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_mapped;
    logic [31:0]       rd_dat;
    logic              rd_ack_q;
    logic              rd_err_q;
    logic              rd_term;
    logic [31:0]       dat_q;

    logic              wr_req_d0;
    logic [31:0]       wr_dat_d0;
    logic [IDX_W-1:0]  wr_idx_d0;
    logic [3:0]        wr_sel_d0;
    logic              wr_mapped;
    logic              wr_ack;
    logic              wr_err;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_old32;
    logic [31:0]       wr_new32;
    logic [NREGS-1:0]  wr_hit;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  wstrb_q;

    // Address low bits, lanes above DATA_W and ro_i of RW slots carry no information here.
    logic              unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[1:0], wr_new32, ro_i};

    assign en        = wb.wb_cyc_i & wb.wb_stb_i;
    assign rd_req    = en & ~wb.wb_we_i & ~rip;
    assign wr_req    = en & wb.wb_we_i & ~wip;
    assign rd_idx    = wb.wb_adr_i[ADR_W-1:2];
    assign rd_mapped = (int'(rd_idx) < NREGS);
    assign rd_term   = rd_ack_q | rd_err_q;

    assign wr_mapped = (int'(wr_idx_d0) < NREGS);
    assign wr_ack    = wr_req_d0 & wr_mapped;
    assign wr_err    = wr_req_d0 & ~wr_mapped;

    assign wb.wb_ack_o   = rd_ack_q | wr_ack;
    assign wb.wb_err_o   = rd_err_q | wr_err;
    assign wb.wb_rty_o   = 1'b0;
    assign wb.wb_stall_o = ~(wb.wb_ack_o | wb.wb_err_o) & en;
    assign wb.wb_dat_o   = dat_q;
    assign wstrb_o       = wstrb_q;

    // Read data mux: RW slots return the register, RO slots the fabric input, unmapped returns 0.
    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (int'(rd_idx) == k) begin
                if (RO_MASK[k]) rd_dat[DATA_W-1:0] = ro_i[k*DATA_W +: DATA_W];
                else            rd_dat[DATA_W-1:0] = regs_q[k];
            end
        end
    end

    // Byte-lane merge of the pending write into the addressed register's current value.
    always_comb begin
        wr_old32 = '0;
        wr_hit   = '0;
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{wr_sel_d0[b]}};
        end
        for (int k = 0; k < NREGS; k++) begin
            if (int'(wr_idx_d0) == k) begin
                wr_old32[DATA_W-1:0] = regs_q[k];
                wr_hit[k]            = wr_req_d0 & ~RO_MASK[k];
            end
        end
        wr_new32 = (wr_old32 & ~wr_mask) | (wr_dat_d0 & wr_mask);
    end

    // Visible register values; read-only slots present 0.
    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NREGS; k++) begin
            regs_o[k*DATA_W +: DATA_W] = RO_MASK[k] ? '0 : regs_q[k];
        end
    end

    // Handshake flags, read termination/data and the write capture stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rip       <= 1'b0;
            wip       <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            dat_q     <= '0;
            wr_req_d0 <= 1'b0;
            wr_dat_d0 <= '0;
            wr_idx_d0 <= '0;
            wr_sel_d0 <= '0;
        end else begin
            // Termination clears a flag with priority so a held strobe re-issues only after it.
            rip       <= rd_term   ? 1'b0 : (rd_req ? 1'b1 : rip);
            wip       <= wr_req_d0 ? 1'b0 : (wr_req ? 1'b1 : wip);
            rd_ack_q  <= rd_req & rd_mapped;
            rd_err_q  <= rd_req & ~rd_mapped;
            if (rd_req) dat_q <= rd_dat;
            wr_req_d0 <= wr_req;
            if (wr_req) begin
                wr_dat_d0 <= wb.wb_dat_i;
                wr_idx_d0 <= wb.wb_adr_i[ADR_W-1:2];
                wr_sel_d0 <= wb.wb_sel_i;
            end
        end
    end

    // Register storage and the one-cycle write strobe that accompanies each new value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= PRESET[k*DATA_W +: DATA_W];
            end
            wstrb_q <= '0;
        end else begin
            wstrb_q <= wr_hit;
            for (int k = 0; k < NREGS; k++) begin
                if (wr_hit[k]) regs_q[k] <= wr_new32[DATA_W-1:0];
            end
        end
    end
endmodule
